pulse_measure: RTL and testbench

PULSE_MEASURE -- requirements
Module: pulse_measure

---
 rtl/pulse_pkg.sv | 30 +++
 rtl/pulse_measure_if.sv | 14 +
 rtl/pulse_sync_edge.sv | 41 ++++
 rtl/pulse_measure.sv | 145 ++++++++++++++
 tb/tb_pulse_measure.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_pkg.sv
// -----------------------------------------------------------------------------
// pulse_pkg
// Shared definitions for the pulse width measurement block and its bench:
//   state_e        - measurement FSM states (ST_IDLE, ST_HIGH, ST_LOW)
//   DEF_EXP_HIGH   - nominal high width in cycles (219)
//   DEF_EXP_LOW    - nominal low width in cycles (440)
//   DEF_TOL        - nominal +/- tolerance in cycles (2)
//   within_tol()   - |val - expv| <= tol without signed arithmetic
// -----------------------------------------------------------------------------
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_e;

  localparam int unsigned DEF_EXP_HIGH = 219;
  localparam int unsigned DEF_EXP_LOW  = 440;
  localparam int unsigned DEF_TOL      = 2;

  // Distance is taken in whichever direction keeps the subtraction positive.
  function automatic logic within_tol(input int unsigned val,
                                      input int unsigned expv,
                                      input int unsigned tol);
    if (val >= expv) return (val - expv) <= tol;
    else             return (expv - val) <= tol;
  endfunction

endpackage

// File: rtl/pulse_measure_if.sv
// -----------------------------------------------------------------------------
// pulse_measure_if
// Edge-event bundle between the synchronizer/edge detector and the FSM.
//   rise    - one-cycle strobe, synchronized rising edge of the pulse
//   fall    - one-cycle strobe, synchronized falling edge of the pulse
// Modports: master drives the strobes, slave consumes them.
// -----------------------------------------------------------------------------
interface pulse_measure_if;
  logic rise;
  logic fall;

  modport master (output rise, fall);
  modport slave  (input  rise, fall);
endinterface

// File: rtl/pulse_sync_edge.sv
// -----------------------------------------------------------------------------
// pulse_sync_edge
// Two-flop synchronizer for the asynchronous pulse input followed by one
// edge-detect flop. The rise/fall strobes are combinational from the last two
// flops, so a consumer registering them acts on the third clock edge after
// the input transition.
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_pulse        - asynchronous pulse train
//   edge_if        - master modport: rise, fall strobes
// -----------------------------------------------------------------------------
module pulse_sync_edge (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pulse,
  pulse_measure_if.master  edge_if
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would collapse
  // the synchronizer chain into a single stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= i_pulse;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  assign edge_if.rise =  sync_2 & ~sync_prev;
  assign edge_if.fall = ~sync_2 &  sync_prev;

endmodule

// File: rtl/pulse_measure.sv
// -----------------------------------------------------------------------------
// pulse_measure
// Measures the high and low widths of an asynchronous pulse train in clock
// cycles. A period is bounded by two synchronized rising edges; at the second
// one the widths are published and o_valid strobes for one cycle.
// Optional feature: define PULSE_MEASURE_CHECK_EN to compare the published
// widths against EXP_HIGH/EXP_LOW +/- TOL on o_match; otherwise o_match is 0.
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_pulse        - asynchronous pulse train
//   o_high_w       - high width of last complete period (saturating)
//   o_low_w        - low width of last complete period (saturating)
//   o_period       - o_high_w + o_low_w, one bit wider
//   o_valid        - one-cycle strobe when the outputs update
//   o_ovf          - a counter saturated during the published period
//   o_match        - published widths within tolerance
// -----------------------------------------------------------------------------
module pulse_measure
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned EXP_HIGH = DEF_EXP_HIGH,
  parameter int unsigned EXP_LOW  = DEF_EXP_LOW,
  parameter int unsigned TOL      = DEF_TOL
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pulse,
  output logic [CNT_W-1:0] o_high_w,
  output logic [CNT_W-1:0] o_low_w,
  output logic [CNT_W:0]   o_period,
  output logic             o_valid,
  output logic             o_ovf,
  output logic             o_match
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pulse_measure_if edge_if ();

  pulse_sync_edge u_sync_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pulse (i_pulse),
    .edge_if (edge_if)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic             ovf_q, ovf_d;
  logic             publish;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      high_q  <= '0;
      low_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      high_q  <= high_d;
      low_q   <= low_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    high_d  = high_q;
    low_d   = low_q;
    ovf_d   = ovf_q;
    publish = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Levels are ignored: capture starts only on a real rising edge.
        if (edge_if.rise) begin
          state_d = ST_HIGH;
          high_d  = CNT_ONE;
          ovf_d   = 1'b0;
        end
      end
      ST_HIGH: begin
        if (edge_if.fall) begin
          state_d = ST_LOW;
          low_d   = CNT_ONE;
        end else if (high_q == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          high_d = high_q + CNT_ONE;
        end
      end
      ST_LOW: begin
        // The rise closes this period and opens the next one in one step.
        if (edge_if.rise) begin
          publish = 1'b1;
          state_d = ST_HIGH;
          high_d  = CNT_ONE;
          ovf_d   = 1'b0;
        end else if (low_q == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          low_d = low_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_high_w <= '0;
      o_low_w  <= '0;
      o_period <= '0;
      o_valid  <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      o_valid <= publish;
      if (publish) begin
        o_high_w <= high_q;
        o_low_w  <= low_q;
        o_period <= {1'b0, high_q} + {1'b0, low_q};
        o_ovf    <= ovf_q;
      end
    end
  end

`ifdef PULSE_MEASURE_CHECK_EN
  logic match_d;

  assign match_d = within_tol(32'(high_q), EXP_HIGH, TOL) &&
                   within_tol(32'(low_q), EXP_LOW, TOL) && !ovf_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     o_match <= 1'b0;
    else if (publish) o_match <= match_d;
  end
`else
  assign o_match = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_measure.sv
// -----------------------------------------------------------------------------
// tb_pulse_measure
// Self-checking bench for pulse_measure. Stimulus is a plan of (level, cycles)
// phases; the reference model derives the expected publications directly from
// the plan: every rising edge after the first closes a period whose widths are
// the preceding high and low phase lengths, saturated at 2^CNT_W-1.
// Build with or without PULSE_MEASURE_CHECK_EN; the model follows the macro.
// -----------------------------------------------------------------------------
module tb_pulse_measure;
  import pulse_pkg::*;

  localparam int CNT_W = 10;
  localparam int MAXV  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] low;
    logic [CNT_W:0]   period;
    logic             ovf;
    logic             match;
  } pub_t;

  typedef struct {
    bit lvl;
    int len;
  } phase_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pulse = 1'b0;
  logic             probe_pulse = 1'b0;
  logic [CNT_W-1:0] o_high_w;
  logic [CNT_W-1:0] o_low_w;
  logic [CNT_W:0]   o_period;
  logic             o_valid;
  logic             o_ovf;
  logic             o_match;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     hold_viol = 0;
  pub_t   mon_q[$];
  int     mon_cyc[$];
  pub_t   exp_q[$];
  int     rise_q[$];
  phase_t plan[$];
  pub_t   last_pub;
  logic   prev_valid;
  pub_t   cur_out;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_measure #(
    .CNT_W    (CNT_W),
    .EXP_HIGH (DEF_EXP_HIGH),
    .EXP_LOW  (DEF_EXP_LOW),
    .TOL      (DEF_TOL)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_pulse  (pulse),
    .o_high_w (o_high_w),
    .o_low_w  (o_low_w),
    .o_period (o_period),
    .o_valid  (o_valid),
    .o_ovf    (o_ovf),
    .o_match  (o_match)
  );

  // Stand-alone edge detector for observing the synchronizer latency.
  pulse_measure_if probe_if ();
  pulse_sync_edge u_probe (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_pulse (probe_pulse),
    .edge_if (probe_if)
  );

  assign cur_out = {o_high_w, o_low_w, o_period, o_ovf, o_match};

  // Collects publications; counts strobes longer than one cycle and output
  // changes that happen without a strobe.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_pub   <= '0;
      prev_valid <= 1'b0;
    end else begin
      if (o_valid) begin
        mon_q.push_back(cur_out);
        mon_cyc.push_back(cyc);
        if (prev_valid) hold_viol <= hold_viol + 1;
        last_pub <= cur_out;
      end else if (cur_out !== last_pub) begin
        hold_viol <= hold_viol + 1;
      end
      prev_valid <= o_valid;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic exp_match(input int h, input int l, input bit ovf);
`ifdef PULSE_MEASURE_CHECK_EN
    int dh, dl;
    dh = (h > int'(DEF_EXP_HIGH)) ? h - int'(DEF_EXP_HIGH) : int'(DEF_EXP_HIGH) - h;
    dl = (l > int'(DEF_EXP_LOW)) ? l - int'(DEF_EXP_LOW) : int'(DEF_EXP_LOW) - l;
    return (dh <= int'(DEF_TOL)) && (dl <= int'(DEF_TOL)) && !ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_expected(input int h, input int l);
    pub_t r;
    int hs, ls;
    bit ov;
    hs = (h > MAXV) ? MAXV : h;
    ls = (l > MAXV) ? MAXV : l;
    ov = (h > MAXV) || (l > MAXV);
    r.high   = CNT_W'(hs);
    r.low    = CNT_W'(ls);
    r.period = (CNT_W + 1)'(hs + ls);
    r.ovf    = ov;
    r.match  = exp_match(hs, ls, ov);
    exp_q.push_back(r);
  endtask

  // Reference model: walk the phase plan, publish at every rise after the first.
  task automatic build_model();
    bit armed, have_l;
    int h, l;
    exp_q.delete();
    armed = 0; have_l = 0; h = 0; l = 0;
    for (int k = 0; k < plan.size(); k++) begin
      if (plan[k].lvl) begin
        if (k == 0 || !plan[k-1].lvl) begin
          if (armed && have_l) push_expected(h, l);
          armed  = 1;
          have_l = 0;
        end
        h = plan[k].len;
      end else if (armed) begin
        l = plan[k].len;
        have_l = 1;
      end
    end
  endtask

  // All drive tasks start and end 2 time units after a rising edge.
  task automatic drive_phase(input bit lvl, input int n);
    pulse = lvl;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    pulse = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic add_phase(input bit lvl, input int n);
    phase_t p;
    p.lvl = lvl;
    p.len = n;
    plan.push_back(p);
  endtask

  task automatic run_plan();
    reset_dut();
    rise_q.delete();
    for (int k = 0; k < plan.size(); k++) begin
      if (plan[k].lvl && (k == 0 || !plan[k-1].lvl)) rise_q.push_back(cyc);
      drive_phase(plan[k].lvl, plan[k].len);
    end
    repeat (6) @(posedge clk);
    #2;
    build_model();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pulse = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({o_high_w, o_low_w} !== '0) begin
      errors++;
      $display("FAIL reset_widths: got high=%0d low=%0d, required 0/0", o_high_w, o_low_w);
    end
    checks++;
    if (o_period !== '0) begin
      errors++;
      $display("FAIL reset_period: got %0d, required 0", o_period);
    end
    checks++;
    if ({o_valid, o_ovf, o_match} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got valid/ovf/match=%b, required 000", {o_valid, o_ovf, o_match});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sync_latency();
    probe_pulse = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    probe_pulse = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({probe_if.rise, probe_if.fall} !== {1'(k == 2), 1'b0}) begin
        errors++;
        $display("FAIL sync_rise edge%0d: got rise/fall=%b%b, required %b0", k,
                 probe_if.rise, probe_if.fall, 1'(k == 2));
      end
    end
    #1;
    probe_pulse = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({probe_if.rise, probe_if.fall} !== {1'b0, 1'(k == 2)}) begin
        errors++;
        $display("FAIL sync_fall edge%0d: got rise/fall=%b%b, required 0%b", k,
                 probe_if.rise, probe_if.fall, 1'(k == 2));
      end
    end
  endtask

  task automatic test_nominal();
    int base, hv;
    plan.delete();
    add_phase(0, 20);
    for (int i = 0; i < 4; i++) begin
      add_phase(1, int'(DEF_EXP_HIGH));
      add_phase(0, int'(DEF_EXP_LOW));
    end
    add_phase(1, int'(DEF_EXP_HIGH));
    base = mon_q.size();
    hv = hold_viol;
    run_plan();
    checks++;
    if (mon_q.size() - base !== exp_q.size()) begin
      errors++;
      $display("FAIL nominal_count: got %0d strobes, required %0d", mon_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL nominal_pub%0d: got %h, required %h", i, mon_q[base+i], exp_q[i]);
      end
      checks++;
      if (mon_cyc[base+i] - rise_q[i+1] !== 3) begin
        errors++;
        $display("FAIL nominal_latency%0d: got %0d cycles, required 3", i, mon_cyc[base+i] - rise_q[i+1]);
      end
    end
    checks++;
    if (hold_viol !== hv) begin
      errors++;
      $display("FAIL nominal_hold: got %0d violations, required 0", hold_viol - hv);
    end
  endtask

  task automatic test_mismatch();
    int base;
    plan.delete();
    add_phase(0, 20);
    add_phase(1, 222);
    add_phase(0, 440);
    add_phase(1, 219);
    add_phase(0, 442);
    add_phase(1, 216);
    add_phase(0, 437);
    add_phase(1, 5);
    base = mon_q.size();
    run_plan();
    checks++;
    if (mon_q.size() - base !== exp_q.size()) begin
      errors++;
      $display("FAIL mismatch_count: got %0d strobes, required %0d", mon_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mismatch_pub%0d: got %h, required %h", i, mon_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int base;
    plan.delete();
    add_phase(0, 20);
    add_phase(1, 1500);
    add_phase(0, 10);
    add_phase(1, int'(DEF_EXP_HIGH));
    add_phase(0, int'(DEF_EXP_LOW));
    add_phase(1, 5);
    base = mon_q.size();
    run_plan();
    checks++;
    if (mon_q.size() - base !== exp_q.size()) begin
      errors++;
      $display("FAIL ovf_count: got %0d strobes, required %0d", mon_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ovf_pub%0d: got %h, required %h", i, mon_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int base;
    reset_dut();
    drive_phase(0, 20);
    drive_phase(1, 219);
    drive_phase(0, 440);
    drive_phase(1, 219);
    drive_phase(0, 100);
    rst_n = 1'b0;
    #1;
    checks++;
    if (cur_out !== '0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: got outputs %h valid %b, required all 0", cur_out, o_valid);
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    base = mon_q.size();
    drive_phase(0, 50);
    drive_phase(1, 219);
    drive_phase(0, 440);
    checks++;
    if (mon_q.size() - base !== 0) begin
      errors++;
      $display("FAIL midreset_early: got %0d strobes after one rise, required 0", mon_q.size() - base);
    end
    drive_phase(1, 10);
    repeat (6) @(posedge clk);
    #2;
    exp_q.delete();
    push_expected(219, 440);
    checks++;
    if (mon_q.size() - base !== 1) begin
      errors++;
      $display("FAIL midreset_count: got %0d strobes, required 1", mon_q.size() - base);
    end else begin
      checks++;
      if (mon_q[base] !== exp_q[0]) begin
        errors++;
        $display("FAIL midreset_pub: got %h, required %h", mon_q[base], exp_q[0]);
      end
    end
  endtask

  task automatic test_glitch();
    int base;
    plan.delete();
    add_phase(0, 20);
    add_phase(1, 219);
    add_phase(0, 200);
    add_phase(1, 1);
    add_phase(0, 240);
    add_phase(1, 219);
    add_phase(0, 440);
    add_phase(1, 10);
    base = mon_q.size();
    run_plan();
    checks++;
    if (mon_q.size() - base !== exp_q.size()) begin
      errors++;
      $display("FAIL glitch_count: got %0d strobes, required %0d", mon_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL glitch_pub%0d: got %h, required %h", i, mon_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int base, hv, h, l;
    plan.delete();
    add_phase(0, 20);
    for (int i = 0; i < 7; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        h = int'(DEF_EXP_HIGH) + int'($urandom_range(0, 8)) - 4;
        l = int'(DEF_EXP_LOW) + int'($urandom_range(0, 8)) - 4;
      end else begin
        h = int'($urandom_range(1, 700));
        l = int'($urandom_range(1, (i == 3) ? 1200 : 700));
      end
      add_phase(1, h);
      add_phase(0, l);
    end
    add_phase(1, 5);
    base = mon_q.size();
    hv = hold_viol;
    run_plan();
    checks++;
    if (mon_q.size() - base !== exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d strobes, required %0d", mon_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_pub%0d: got %h, required %h", i, mon_q[base+i], exp_q[i]);
      end
    end
    checks++;
    if (hold_viol !== hv) begin
      errors++;
      $display("FAIL random_hold: got %0d violations, required 0", hold_viol - hv);
    end
  endtask

  initial begin
    test_reset();
    test_sync_latency();
    test_nominal();
    test_mismatch();
    test_overflow();
    test_mid_reset();
    test_glitch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
